// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and byte/word helpers for the decrypt core.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ARK_INIT,
        INV_SR,
        INV_SB,
        ARK,
        INV_MC,
        DONE
    } aes_state_t;

    // Number of rounds for AES-128; also the index of the last round key.
    localparam logic [3:0] NR = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add; constant b folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // One column of InvMixColumns; row 0 is the most significant byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Row n of the column-major state rotates right by n byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Forward S-box applied to each byte of a key-schedule word.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_schedule.sv
// AES-128 round-key store: loads rk0, then computes one round key per step strobe.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic         i_load,
    input  logic [127:0] i_key,
    input  logic         i_step,
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rk,
    output logic         o_last
);

    logic [127:0] r_rk [0:10];
    // Copy of the most recently produced key so expansion needs no read mux.
    logic [127:0] r_work;
    logic [3:0]   r_idx;

    logic [31:0]  w_temp;
    logic [7:0]   w_rcon;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next;

    // Next round key from the previous one: RotWord, SubWord, Rcon, then XOR chain.
    always_comb begin
        w_rcon = (r_idx >= 4'd1 && r_idx <= NR) ? RCON[r_idx] : 8'h00;
        w_temp = sub_word({r_work[23:0], r_work[31:24]}) ^ {w_rcon, 24'h000000};
        w_n0   = r_work[127:96] ^ w_temp;
        w_n1   = r_work[95:64]  ^ w_n0;
        w_n2   = r_work[63:32]  ^ w_n1;
        w_n3   = r_work[31:0]   ^ w_n2;
        w_next = {w_n0, w_n1, w_n2, w_n3};
    end

    // Round-key store: rk0 on load, rk[r_idx] on each step.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int k = 0; k <= 10; k++) begin
                r_rk[k] <= '0;
            end
            r_work <= '0;
            r_idx  <= 4'd0;
        end else if (i_load) begin
            r_rk[0] <= i_key;
            r_work  <= i_key;
            r_idx   <= 4'd1;
        end else if (i_step) begin
            for (int k = 1; k <= 10; k++) begin
                if (r_idx == 4'(k)) begin
                    r_rk[k] <= w_next;
                end
            end
            r_work <= w_next;
            r_idx  <= r_idx + 4'd1;
        end
    end

    assign o_rk   = (i_rd_idx <= NR) ? r_rk[i_rd_idx] : '0;
    assign o_last = (r_idx == NR);

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption: one sub-operation (SR, SB, ARK or MC) per clock.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_ENC,
    output logic [127:0] AES_MSG_DEC,
    output logic         AES_DONE
);

    // Boundary registers: the FSM acts on these one edge after sampling.
    logic         r_start;
    logic [127:0] r_key_in;
    logic [127:0] r_msg_in;

    aes_state_t   r_state;
    logic [127:0] r_data;
    logic [3:0]   r_round;
    logic [127:0] r_msg_dec;
    logic         r_done;

    logic         w_ks_load;
    logic         w_ks_step;
    logic         w_ks_last;
    logic [3:0]   w_rk_idx;
    logic [127:0] w_rk;
    logic [127:0] w_inv_sr;
    logic [127:0] w_inv_sb;
    logic [127:0] w_inv_mc;
    logic [127:0] w_ark;

    // Register the start bit, key and ciphertext at the core boundary.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_start  <= 1'b0;
            r_key_in <= '0;
            r_msg_in <= '0;
        end else begin
            r_start  <= AES_START;
            r_key_in <= AES_KEY;
            r_msg_in <= AES_MSG_ENC;
        end
    end

    assign w_ks_load = (r_state == IDLE) && r_start;
    assign w_ks_step = (r_state == KEYEXP);
    // The initial whitening uses rk10; every later ARK uses the round counter.
    assign w_rk_idx  = (r_state == ARK_INIT) ? NR : r_round;

    aes_key_schedule u_key_schedule (
        .i_clk    (CLK),
        .i_srst   (RESET),
        .i_load   (w_ks_load),
        .i_key    (r_key_in),
        .i_step   (w_ks_step),
        .i_rd_idx (w_rk_idx),
        .o_rk     (w_rk),
        .o_last   (w_ks_last)
    );

    assign w_inv_sr = inv_shift_rows(r_data);
    assign w_ark    = r_data ^ w_rk;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_inv_sb
            assign w_inv_sb[127-8*gi -: 8] = INV_SBOX[r_data[127-8*gi -: 8]];
        end
        for (gi = 0; gi < 4; gi++) begin : g_inv_mc
            assign w_inv_mc[127-32*gi -: 32] = inv_mix_column(r_data[127-32*gi -: 32]);
        end
    endgenerate

    // Sequencer: key expansion, whitening, 9 full rounds, final round, done handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_round   <= 4'd0;
            r_msg_dec <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_start) begin
                        r_data  <= r_msg_in;
                        r_round <= 4'd0;
                        r_state <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    if (w_ks_last) begin
                        r_state <= ARK_INIT;
                    end
                end
                ARK_INIT: begin
                    r_data  <= w_ark;
                    r_round <= NR - 4'd1;
                    r_state <= INV_SR;
                end
                INV_SR: begin
                    r_data  <= w_inv_sr;
                    r_state <= INV_SB;
                end
                INV_SB: begin
                    r_data  <= w_inv_sb;
                    r_state <= ARK;
                end
                ARK: begin
                    r_data <= w_ark;
                    // Round 0 has no InvMixColumns and produces the plaintext.
                    if (r_round == 4'd0) begin
                        r_msg_dec <= w_ark;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state <= INV_MC;
                    end
                end
                INV_MC: begin
                    r_data  <= w_inv_mc;
                    r_round <= r_round - 4'd1;
                    r_state <= INV_SR;
                end
                DONE: begin
                    if (!r_start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign AES_MSG_DEC = r_msg_dec;
    assign AES_DONE    = r_done;

endmodule
